// File: rtl/ipml_prefetch_fifo_pkg.sv
// Shared constants and helpers for the v2 prefetch FIFO.
// Capacity, level width and legal parameter ranges live here.
package ipml_prefetch_fifo_pkg;

    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 2;
    localparam int DEPTH_W_MIN = 2;
    localparam int DEPTH_W_MAX = 16;
    localparam int DATA_W_MIN  = 1;
    localparam int DATA_W_MAX  = 1152;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // The register stage covers the RAM latency plus the head word.
    function automatic int ostage_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

    function automatic int capacity(input int depth_w, input int rd_lat);
        return (1 << depth_w) + ostage_depth(rd_lat);
    endfunction

    function automatic int level_width(input int depth_w);
        return depth_w + 2;
    endfunction

    function automatic bit params_legal(
        input int data_w,
        input int depth_w,
        input int rd_lat
    );
        return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX)
            && (depth_w >= DEPTH_W_MIN) && (depth_w <= DEPTH_W_MAX)
            && (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX);
    endfunction

endpackage

// File: rtl/ipml_prefetch_fifo_sync_v2_0_if.sv
// Write/read stream bundle of the v2 prefetch FIFO.
// Optional error flags: IPML_PREFETCH_FIFO_ERR_FLAG_EN.
interface ipml_prefetch_fifo_sync_v2_0_if #(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 10
);
    import ipml_prefetch_fifo_pkg::*;

    localparam int LW = level_width(c_DEPTH_WIDTH);

    logic [c_DATA_WIDTH-1:0] wr_data;
    logic                    wr_en;
    logic                    wr_vld;
    logic [c_DATA_WIDTH-1:0] rd_data;
    logic                    rd_en;
    logic                    rd_vld;
    logic [LW-1:0]           level;
    logic                    almost_full;
    logic                    almost_empty;

`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
    logic overflow;
    logic underflow;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_vld, rd_data, rd_vld, level,
        input  almost_full, almost_empty,
        input  overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_vld, rd_data, rd_vld, level,
        output almost_full, almost_empty,
        output overflow, underflow
    );
`else
    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_vld, rd_data, rd_vld, level,
        input  almost_full, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_vld, rd_data, rd_vld, level,
        output almost_full, almost_empty
    );
`endif

endinterface

// File: rtl/ipml_prefetch_fifo_sync_v2_0_reg_fifo.sv
// Small register FIFO used as the show-ahead output stage.
// Head word always sits in mem[0]; pops shift toward it.
module ipml_reg_fifo_v2_0
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int OW    = clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [OW-1:0] occ
);

    logic [W-1:0] mem [DEPTH];

    assign dout = mem[0];

    // Shift on pop, then land a push just past the surviving entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[DEPTH-1] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (i == int'(occ) - int'(pop))) begin
                    mem[i] <= din;
                end
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

endmodule

// File: rtl/ipml_prefetch_fifo_sync_v2_0.sv
// Single-clock show-ahead FIFO: SDP RAM plus register output stage.
// Optional error flags: IPML_PREFETCH_FIFO_ERR_FLAG_EN.
module ipml_prefetch_fifo_sync_v2_0
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_RAM_RD_LATENCY   = 1,
    parameter int c_ALMOST_FULL_NUM  = (1 << c_DEPTH_WIDTH) - 4,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input logic clk,
    input logic rst,
    ipml_prefetch_fifo_sync_v2_0_if.slave bus
);

    localparam int K  = ostage_depth(c_RAM_RD_LATENCY);
    localparam int OW = clog2(K + 1);
    localparam int AW = c_DEPTH_WIDTH;
    localparam int CW = AW + 1;
    localparam int LW = level_width(AW);
    localparam int L  = c_RAM_RD_LATENCY;
    localparam logic [CW-1:0] RAM_WORDS = CW'(1 << AW);

    if (!params_legal(c_DATA_WIDTH, c_DEPTH_WIDTH, c_RAM_RD_LATENCY))
    begin : g_bad_param
        $error("ipml_prefetch_fifo_sync_v2_0: parameter out of range");
    end

    logic [c_DATA_WIDTH-1:0] ram [1 << AW];
    logic [c_DATA_WIDTH-1:0] rdata_q [L];
    logic [c_DATA_WIDTH-1:0] ost_dout;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [CW-1:0]           ram_cnt;
    logic [CW-1:0]           ram_cnt_nxt;
    logic [LW-1:0]           level_q;
    logic [LW-1:0]           level_nxt;
    logic [L-1:0]            vld_sr;
    logic [OW-1:0]           occ;
    logic [OW-1:0]           inflight;
    logic                    wr_vld_q;
    logic                    af_q;
    logic                    ae_q;
    logic                    wr_acc;
    logic                    pop;
    logic                    rd_issue;

    assign wr_acc = bus.wr_en & wr_vld_q;
    assign pop    = bus.rd_en & (occ != '0);

    // Count reads in flight and decide whether to prefetch another word.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < L; i++) begin
            inflight = inflight + OW'(vld_sr[i]);
        end
        rd_issue = (ram_cnt != '0)
            && ((int'(occ) + int'(inflight) - int'(pop)) < K);
        ram_cnt_nxt = ram_cnt + CW'(wr_acc) - CW'(rd_issue);
        level_nxt   = level_q + LW'(wr_acc) - LW'(pop);
    end

    // RAM write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            ram[wptr] <= bus.wr_data;
        end
    end

    // RAM read port with optional output register stage.
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            rdata_q[0] <= ram[rptr];
        end
        for (int i = 1; i < L; i++) begin
            rdata_q[i] <= rdata_q[i-1];
        end
    end

    // Pointers, counts, read-valid pipe and flags from next-state counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            level_q  <= '0;
            vld_sr   <= '0;
            wr_vld_q <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_issue) begin
                rptr <= rptr + 1'b1;
            end
            ram_cnt  <= ram_cnt_nxt;
            level_q  <= level_nxt;
            vld_sr   <= (vld_sr << 1) | L'(rd_issue);
            wr_vld_q <= (ram_cnt_nxt != RAM_WORDS);
            af_q     <= (int'(ram_cnt_nxt) >= c_ALMOST_FULL_NUM);
            ae_q     <= (int'(level_nxt) <= c_ALMOST_EMPTY_NUM);
        end
    end

    ipml_reg_fifo_v2_0 #(
        .W     (c_DATA_WIDTH),
        .DEPTH (K)
    ) u_ostage (
        .clk  (clk),
        .rst  (rst),
        .push (vld_sr[L-1]),
        .din  (rdata_q[L-1]),
        .pop  (pop),
        .dout (ost_dout),
        .occ  (occ)
    );

    assign bus.wr_vld       = wr_vld_q;
    assign bus.rd_vld       = (occ != '0);
    assign bus.rd_data      = ost_dout;
    assign bus.level        = level_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;

`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags for refused requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.wr_en & ~wr_vld_q);
            udf_q <= udf_q | (bus.rd_en & (occ == '0));
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`endif

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_v2_0.sv
// Bench for the v2 prefetch FIFO: latency-1 and latency-2 instances
// share stimulus; a negedge monitor checks against a scoreboard.
`timescale 1ns/1ps
module tb_ipml_prefetch_fifo_sync_v2_0;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int LW   = AW + 2;
    localparam int RAMW = 16;
    localparam int AF   = 12;
    localparam int AE   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ipml_prefetch_fifo_sync_v2_0_if #(
        .c_DATA_WIDTH (DW),
        .c_DEPTH_WIDTH(AW)
    ) b0 (), b1 ();

    ipml_prefetch_fifo_sync_v2_0 #(
        .c_DATA_WIDTH      (DW),
        .c_DEPTH_WIDTH     (AW),
        .c_RAM_RD_LATENCY  (1),
        .c_ALMOST_FULL_NUM (AF),
        .c_ALMOST_EMPTY_NUM(AE)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(b0.slave)
    );

    ipml_prefetch_fifo_sync_v2_0 #(
        .c_DATA_WIDTH      (DW),
        .c_DEPTH_WIDTH     (AW),
        .c_RAM_RD_LATENCY  (2),
        .c_ALMOST_FULL_NUM (AF),
        .c_ALMOST_EMPTY_NUM(AE)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1.slave)
    );

    assign b0.wr_en   = wr_en;
    assign b0.rd_en   = rd_en;
    assign b0.wr_data = wr_data;
    assign b1.wr_en   = wr_en;
    assign b1.rd_en   = rd_en;
    assign b1.wr_data = wr_data;

    logic          rv  [2];
    logic          wv  [2];
    logic          afl [2];
    logic          ael [2];
    logic [DW-1:0] rdd [2];
    logic [LW-1:0] lvl [2];
    logic [1:0]    occ [2];

    assign rv[0]  = b0.rd_vld;
    assign rv[1]  = b1.rd_vld;
    assign wv[0]  = b0.wr_vld;
    assign wv[1]  = b1.wr_vld;
    assign afl[0] = b0.almost_full;
    assign afl[1] = b1.almost_full;
    assign ael[0] = b0.almost_empty;
    assign ael[1] = b1.almost_empty;
    assign rdd[0] = b0.rd_data;
    assign rdd[1] = b1.rd_data;
    assign lvl[0] = b0.level;
    assign lvl[1] = b1.level;
    assign occ[0] = u_dut0.u_ostage.occ;
    assign occ[1] = u_dut1.u_ostage.occ;

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model state, one slot per instance.
    int         m_ram [2];
    int         m_occ [2];
    int         m_lvl [2];
    logic [1:0] m_vsr [2];
    logic [DW-1:0] exp_q [2][$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ram[d] = 0;
            m_occ[d] = 0;
            m_lvl[d] = 0;
            m_vsr[d] = '0;
        end
    end

    // Monitor: compare outputs, then advance the model for the next edge.
    always @(negedge clk) begin
        int lat;
        int k;
        int infl;
        int acc;
        int pop;
        int iss;
        int push;
        for (int d = 0; d < 2; d++) begin
            lat = d + 1;
            k   = lat + 1;
            if (rst) begin
                chk("rst_rd_vld", 32'(rv[d]), 0);
                chk("rst_rd_data", 32'(rdd[d]), 0);
                chk("rst_level", 32'(lvl[d]), 0);
                chk("rst_wr_vld", 32'(wv[d]), 1);
                chk("rst_almost_full", 32'(afl[d]), 0);
                chk("rst_almost_empty", 32'(ael[d]), 1);
                m_ram[d] = 0;
                m_occ[d] = 0;
                m_lvl[d] = 0;
                m_vsr[d] = '0;
                exp_q[d].delete();
            end else begin
                chk("rd_vld", 32'(rv[d]), 32'(m_occ[d] != 0));
                chk("level", 32'(lvl[d]), m_lvl[d]);
                chk("wr_vld", 32'(wv[d]), 32'(m_ram[d] != RAMW));
                chk("almost_full", 32'(afl[d]), 32'(m_ram[d] >= AF));
                chk("almost_empty", 32'(ael[d]), 32'(m_lvl[d] <= AE));
                chk("ostage_bound", 32'(occ[d] <= 2'(k)), 1);
                if (rv[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("rd_data_spurious", 32'(rdd[d]), 32'hFFFF_FFFF);
                    end else begin
                        chk("rd_data", 32'(rdd[d]), 32'(exp_q[d][0]));
                    end
                end
                acc  = (wr_en && m_ram[d] != RAMW) ? 1 : 0;
                pop  = (rd_en && m_occ[d] != 0) ? 1 : 0;
                infl = int'(m_vsr[d][0]) + int'(m_vsr[d][1]);
                iss  = (m_ram[d] != 0 && (m_occ[d] + infl - pop) < k) ? 1 : 0;
                push = int'(m_vsr[d][lat-1]);
                if (acc == 1) begin
                    exp_q[d].push_back(wr_data);
                end
                if (pop == 1 && exp_q[d].size() != 0) begin
                    void'(exp_q[d].pop_front());
                end
                m_ram[d] = m_ram[d] + acc - iss;
                m_occ[d] = m_occ[d] + push - pop;
                m_lvl[d] = m_lvl[d] + acc - pop;
                m_vsr[d] = (lat == 1) ? {1'b0, iss[0]} : {m_vsr[d][0], iss[0]};
            end
        end
    end

    task automatic step(
        input logic          w,
        input logic [DW-1:0] d,
        input logic          r
    );
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("hold_rst_level", 32'(lvl[d]), 0);
            chk("hold_rst_rd_vld", 32'(rv[d]), 0);
            chk("hold_rst_wr_vld", 32'(wv[d]), 1);
        end
        rst = 1'b0;

        // First-word latency.
        step(1'b1, 8'hA5, 1'b0);
        chk("t1_level0", 32'(lvl[0]), 1);
        chk("t1_level1", 32'(lvl[1]), 1);
        chk("t1_early0", 32'(rv[0]), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_e1_vld0", 32'(rv[0]), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_e2_vld0", 32'(rv[0]), 1);
        chk("t1_e2_data0", 32'(rdd[0]), 32'hA5);
        chk("t1_e2_vld1", 32'(rv[1]), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_e3_vld1", 32'(rv[1]), 1);
        chk("t1_e3_data1", 32'(rdd[1]), 32'hA5);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_popped0", 32'(lvl[0]), 0);
        chk("t1_popped1", 32'(lvl[1]), 0);

        // Fill past capacity, then drain.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        chk("t2_level0", 32'(lvl[0]), 18);
        chk("t2_level1", 32'(lvl[1]), 19);
        chk("t2_wr_vld0", 32'(wv[0]), 0);
        chk("t2_wr_vld1", 32'(wv[1]), 0);
        chk("t2_af0", 32'(afl[0]), 1);
        chk("t2_af1", 32'(afl[1]), 1);
        chk("t2_head0", 32'(rdd[0]), 0);
        repeat (22) step(1'b0, 8'h00, 1'b1);
        chk("t2_drained0", 32'(lvl[0]), 0);
        chk("t2_drained1", 32'(lvl[1]), 0);

        // Streaming at one word per cycle.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i + 8'h80), 1'b1);
            if (i >= 4) begin
                chk("t3_vld0", 32'(rv[0]), 1);
                chk("t3_vld1", 32'(rv[1]), 1);
                chk("t3_level0", 32'(lvl[0]), 3);
                chk("t3_level1", 32'(lvl[1]), 4);
            end
        end
        repeat (8) step(1'b0, 8'h00, 1'b1);
        chk("t3_drained0", 32'(lvl[0]), 0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)));
        end
        repeat (25) step(1'b0, 8'h00, 1'b1);
        chk("t4_drained0", 32'(lvl[0]), 0);
        chk("t4_drained1", 32'(lvl[1]), 0);

        // Reset with nine words held.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
        end
        chk("t5_level0", 32'(lvl[0]), 9);
        chk("t5_level1", 32'(lvl[1]), 9);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("t5_rd_vld", 32'(rv[d]), 0);
            chk("t5_level", 32'(lvl[d]), 0);
            chk("t5_wr_vld", 32'(wv[d]), 1);
        end
        step(1'b1, 8'h3C, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("t5_first_vld", 32'(rv[d]), 1);
            chk("t5_first_data", 32'(rdd[d]), 32'h3C);
        end
        step(1'b0, 8'h00, 1'b1);

`ifdef IPML_PREFETCH_FIFO_ERR_FLAG_EN
        // Sticky error flags.
        chk("t6_udf_clear", 32'(b0.underflow), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_udf_set0", 32'(b0.underflow), 1);
        chk("t6_udf_set1", 32'(b1.underflow), 1);
        chk("t6_ovf_clear", 32'(b0.overflow), 0);
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        chk("t6_ovf_set0", 32'(b0.overflow), 1);
        chk("t6_ovf_set1", 32'(b1.overflow), 1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("t6_udf_held", 32'(b0.underflow), 1);
        chk("t6_ovf_held", 32'(b0.overflow), 1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("t6_ovf_rst", 32'(b1.overflow), 0);
        chk("t6_udf_rst", 32'(b1.underflow), 0);
`endif

        step(1'b0, 8'h00, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
